qspi_ctrl: RTL and testbench
============================

# qspi_ctrl

- Host-side QSPI master for the TinyQV memory PMOD (one flash, RAM A, RAM B).
- Accepts single read/write requests of 1–4 bytes from the CPU memory interface and converts them into nibble-serial transactions.
- Drives `qspi_clk`, the data lines and the three active-low selects.
- Sits directly upstream of the PMOD memory model/device.

## Interface
Parameters:
- `RD_DELAY`, 2, rising `qspi_clk` edges from end of dummy phase to first valid read nibble; first data sampled at rising edge 12+`RD_DELAY`.

Ports:
- `clk` in 1: system clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on a cycle where `req_valid` and `req_ready` are both 1.
- `req_sel` in 2: target select; 0 = flash, 1 = RAM A, 2 = RAM B, 3 = illegal.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 24: byte address.
- `req_len` in 2: byte count minus 1 (1–4 bytes).
- `req_wdata` in 32: write data; byte i is `[8i+7:8i]`.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: read bytes, little-endian; bytes not read are 0. Held until the next response.
- `resp_error` out 1: qualifies `resp_valid`.
- `qspi_clk` out 1: serial clock, registered.
- `qspi_data_out` out 4: nibble driven to the memory.
- `qspi_data_oe` out 1: 1 = controller drives the data lines.
- `qspi_data_in` in 4: nibble from the memory.
- `qspi_flash_select`, `qspi_ram_a_select`, `qspi_ram_b_select` out 1 each: active-low chip selects.

## Operation
- States: IDLE, CMD, ADDR, MODE, DUMMY, WDATA, RDATA, DONE, DESEL.
- A 4-bit nibble counter is reloaded on each state entry.
- Flash read: ADDR (6 nibbles) → MODE (nibbles 0xA, 0x0) → DUMMY (4) → RDATA.
  - No command byte: the flash runs in continuous-read mode.
- RAM read: CMD (0x0, 0xB) → ADDR (6) → DUMMY (4) → RDATA.
- RAM write: CMD (0x0, 0x2) → ADDR (6) → WDATA (2×len nibbles).
- Nibble order:
  - Address: most-significant nibble first.
  - Data: byte 0 first, high nibble before low nibble.
- RDATA phase:
  - Spans rising edges 12+`RD_DELAY` through 12+`RD_DELAY`+2·len−1.
  - Rising edges before 12+`RD_DELAY` that fall after DUMMY are clocked with `qspi_data_oe`=0 and their samples are discarded.
- `qspi_data_oe` is 1 in CMD/ADDR/MODE/WDATA and 0 in DUMMY/RDATA/DONE/DESEL/IDLE.
- Illegal requests (`req_sel`=3, or a flash write):
  - Accepted normally, with no bus activity.
  - `resp_valid`=1 and `resp_error`=1 on the cycle after acceptance; `resp_rdata` = 0.
- DONE: one cycle with `qspi_clk`=0 and the select still low.
- DESEL:
  - Select goes high; `resp_valid` pulses on the first DESEL cycle.
  - DESEL lasts 2 cycles; then IDLE.
  - `req_ready`=1 only in IDLE, so no request is accepted while a transaction is in progress.
- Reset values: `qspi_clk`=0, `qspi_data_out`=0, `qspi_data_oe`=0, all selects=1, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_error`=0; state IDLE.
- Reset mid-transaction: selects rise immediately; no response is produced for the aborted request.

## Timing
- Each nibble takes 2 `clk` cycles:
  - Low phase: `qspi_clk`=0, new nibble driven.
  - High phase: `qspi_clk`=1.
- The memory captures on the `qspi_clk` rising edge and updates its output on the falling edge.
- The controller samples `qspi_data_in` on the `clk` edge that raises `qspi_clk`, i.e. at the end of the low phase.
- Cycle numbering, with acceptance on cycle 0:
  - Select goes low and the first nibble is driven on cycle 1.
  - For N nibble periods, cycles 1..2N are the nibble phases.
  - Cycle 2N+1 is DONE.
  - Cycle 2N+2 is the first DESEL cycle: select high, `resp_valid`=1.
  - `req_ready`=1 from cycle 2N+4.
- Nibble counts N:
  - Flash read: 12+`RD_DELAY`+2·len−1.
  - RAM read: the same.
  - RAM write: 8+2·len.
- With default `RD_DELAY`=2, a 4-byte flash read gives `resp_valid` on cycle 44.

## Configuration
- `QSPI_CTRL_ABORT_EN` defined: adds input port `abort` (1 bit).
  - `abort`=1 in any state from CMD to DONE: next cycle is DESEL with select high; `resp_valid`=1, `resp_error`=1.
  - `resp_rdata` holds the bytes fully received so far; other bytes are 0.
  - Then the normal 2-cycle DESEL.
  - `abort` in IDLE or DESEL is ignored.
- `QSPI_CTRL_ABORT_EN` undefined: the port is absent and transactions always complete.

## Test plan
- Flash read:
  - Stimulus: sel=0, addr=0x000010, len=3; model byte 0x10..0x13 = 11 22 33 44.
  - Required: nibbles 0,0,0,0,1,0,A,0 driven with oe=1; `resp_rdata`=0x44332211; `resp_valid` on cycle 44; `resp_error`=0.
- RAM A write then read:
  - Stimulus: write 0xDEADBEEF to 0x000100 (len=3), then read back.
  - Required: CMD nibbles 0,2 for the write and 0,B for the read; `resp_valid` on cycle 34 after the write's acceptance; read returns 0xDEADBEEF; `qspi_ram_a_select` is the only select that toggles.
- RAM B 1-byte read:
  - Stimulus: len=0; model byte 0x5A.
  - Required: `resp_rdata`=0x0000005A; exactly 2 data nibbles sampled.
- Illegal requests:
  - Stimulus: sel=3, then a flash write.
  - Required: no select ever goes low; `resp_valid` and `resp_error` on cycle 1; `resp_rdata`=0.
- Back-to-back and reset:
  - Stimulus: `req_valid` held high across a transaction.
  - Required: second accept is no earlier than cycle 2N+4, and the select stays high for ≥2 cycles between transactions.
  - Stimulus: `rst` asserted mid-ADDR.
  - Required: all selects high in the same cycle, no `resp_valid`, `req_ready`=1 after release.
- Abort (with `QSPI_CTRL_ABORT_EN`):
  - Stimulus: `abort` after the first RAM read byte has been received.
  - Required: select high on the next cycle; `resp_error`=1; `resp_rdata` byte 0 = the model byte, other bytes 0.

Source files
------------

// File: rtl/qspi_ctrl.sv
// qspi_ctrl: host QSPI master for the TinyQV memory PMOD (flash, RAM A, RAM B).
// Define QSPI_CTRL_ABORT_EN to add the `abort` input.
module qspi_ctrl #(
    parameter int RD_DELAY = 2
) (
    input  logic        clk,
    input  logic        rst,
`ifdef QSPI_CTRL_ABORT_EN
    input  logic        abort,
`endif
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_sel,
    input  logic        req_write,
    input  logic [23:0] req_addr,
    input  logic [1:0]  req_len,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        qspi_clk,
    output logic [3:0]  qspi_data_out,
    output logic        qspi_data_oe,
    input  logic [3:0]  qspi_data_in,
    output logic        qspi_flash_select,
    output logic        qspi_ram_a_select,
    output logic        qspi_ram_b_select
);
    typedef enum logic [3:0] {
        IDLE, CMD, ADDR, MODE, DUMMY, WDATA, RDATA, DONE, DESEL
    } state_t;

    state_t      state, state_d, nxt;
    logic [3:0]  cnt, cnt_d, last, nib_d, nib_hi;
    logic [4:0]  sh;
    logic        flash_q, wr_q;
    logic [1:0]  len_q;
    logic [23:0] addr_q, cur_addr;
    logic [31:0] wdata_q, rbuf;
    logic [2:0]  cs_n;
    logic        accept, illegal, active, abort_hit;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign illegal   = (req_sel == 2'd3) || (req_sel == 2'd0 && req_write);
    assign active    = state inside {CMD, ADDR, MODE, DUMMY, WDATA, RDATA};

`ifdef QSPI_CTRL_ABORT_EN
    assign abort_hit = abort && state != IDLE && state != DESEL;
`else
    assign abort_hit = 1'b0;
`endif

    assign qspi_flash_select = cs_n[0];
    assign qspi_ram_a_select = cs_n[1];
    assign qspi_ram_b_select = cs_n[2];

    // DUMMY also covers the discarded edges before read data is valid
    always_comb begin
        last = 4'd0;
        nxt  = DONE;
        case (state)
            CMD:   begin last = 4'd1; nxt = ADDR; end
            ADDR: begin
                last = 4'd5;
                nxt  = flash_q ? MODE : (wr_q ? WDATA : DUMMY);
            end
            MODE:  begin last = 4'd1; nxt = DUMMY; end
            DUMMY: begin last = 4'(RD_DELAY + 2); nxt = RDATA; end
            WDATA, RDATA: last = {1'b0, len_q, 1'b1};
            default: last = 4'd0;
        endcase
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (accept && !illegal) begin
                    state_d = (req_sel == 2'd0) ? ADDR : CMD;
                    cnt_d   = 4'd0;
                end
            end
            DONE: begin
                state_d = DESEL;
                cnt_d   = 4'd0;
            end
            DESEL: begin
                if (cnt != 4'd0) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = 4'd1;
                end
            end
            default: begin
                if (qspi_clk) begin
                    if (cnt == last) begin
                        state_d = nxt;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt + 4'd1;
                    end
                end
            end
        endcase
        if (abort_hit) begin
            state_d = DESEL;
            cnt_d   = 4'd0;
        end
    end

    always_comb begin
        cur_addr = (state == IDLE) ? req_addr : addr_q;
        sh       = 5'd20 - {cnt_d[2:0], 2'b00};
        nib_d    = 4'h0;
        case (state_d)
            CMD:   nib_d = cnt_d[0] ? (wr_q ? 4'h2 : 4'hB) : 4'h0;
            ADDR:  nib_d = cur_addr[sh +: 4];
            MODE:  nib_d = cnt_d[0] ? 4'h0 : 4'hA;
            WDATA: nib_d = wdata_q[{cnt_d[2:1], ~cnt_d[0], 2'b00} +: 4];
            default: nib_d = 4'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qspi_clk      <= 1'b0;
            qspi_data_out <= 4'h0;
            qspi_data_oe  <= 1'b0;
            cs_n          <= 3'b111;
            resp_valid    <= 1'b0;
            resp_error    <= 1'b0;
            resp_rdata    <= 32'h0;
            flash_q       <= 1'b0;
            wr_q          <= 1'b0;
            len_q         <= 2'd0;
            addr_q        <= 24'h0;
            wdata_q       <= 32'h0;
            rbuf          <= 32'h0;
            nib_hi        <= 4'h0;
        end else begin
            resp_valid <= 1'b0;
            if (abort_hit) begin
                qspi_clk      <= 1'b0;
                qspi_data_out <= 4'h0;
                qspi_data_oe  <= 1'b0;
                cs_n          <= 3'b111;
                resp_valid    <= 1'b1;
                resp_error    <= 1'b1;
                resp_rdata    <= rbuf;
            end else if (accept) begin
                flash_q <= (req_sel == 2'd0);
                wr_q    <= req_write;
                len_q   <= req_len;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rbuf    <= 32'h0;
                if (illegal) begin
                    resp_valid <= 1'b1;
                    resp_error <= 1'b1;
                    resp_rdata <= 32'h0;
                end else begin
                    cs_n          <= ~(3'b001 << req_sel);
                    qspi_data_out <= nib_d;
                    qspi_data_oe  <= 1'b1;
                end
            end else if (active) begin
                if (!qspi_clk) begin
                    qspi_clk <= 1'b1;
                    // only whole bytes land in rbuf, so an abort never shows half a byte
                    if (state == RDATA) begin
                        if (!cnt[0])
                            nib_hi <= qspi_data_in;
                        else
                            rbuf[{cnt[2:1], 3'b000} +: 8] <= {nib_hi, qspi_data_in};
                    end
                end else begin
                    qspi_clk      <= 1'b0;
                    qspi_data_out <= nib_d;
                    qspi_data_oe  <= state_d inside {CMD, ADDR, MODE, WDATA};
                end
            end else if (state == DONE) begin
                cs_n       <= 3'b111;
                resp_valid <= 1'b1;
                resp_error <= 1'b0;
                resp_rdata <= rbuf;
            end
        end
    end
endmodule

// File: tb/tb_qspi_ctrl.sv
// tb_qspi_ctrl: table vectors, random traffic and corner sequences for qspi_ctrl
// against a nibble-level PMOD memory model and a byte-level reference memory.
module tb_qspi_ctrl;
    localparam int RD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [1:0]  req_sel, req_len;
    logic [23:0] req_addr;
    logic [31:0] req_wdata, resp_rdata;
    logic        resp_valid, resp_error;
    logic        qspi_clk, qspi_data_oe;
    logic [3:0]  qspi_data_out, qspi_data_in;
    logic        qspi_flash_select, qspi_ram_a_select, qspi_ram_b_select;
`ifdef QSPI_CTRL_ABORT_EN
    logic        abort;
`endif

    qspi_ctrl #(.RD_DELAY(RD)) dut (
        .clk(clk), .rst(rst),
`ifdef QSPI_CTRL_ABORT_EN
        .abort(abort),
`endif
        .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
        .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
        .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_error(resp_error),
        .qspi_clk(qspi_clk), .qspi_data_out(qspi_data_out),
        .qspi_data_oe(qspi_data_oe), .qspi_data_in(qspi_data_in),
        .qspi_flash_select(qspi_flash_select),
        .qspi_ram_a_select(qspi_ram_a_select),
        .qspi_ram_b_select(qspi_ram_b_select)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // memories keyed by select*2^24 + address
    logic [7:0] mem [int];
    logic [7:0] ref_m [int];

    function automatic int key(input int s, input logic [23:0] a);
        return s * 16777216 + int'({8'h00, a});
    endfunction

    function automatic logic [7:0] mget(input int s, input logic [23:0] a);
        int k = key(s, a);
        return mem.exists(k) ? mem[k] : 8'h00;
    endfunction

    function automatic logic [7:0] rget(input int s, input logic [23:0] a);
        int k = key(s, a);
        return ref_m.exists(k) ? ref_m[k] : 8'h00;
    endfunction

    task automatic preload(input int s, input logic [23:0] a, input logic [7:0] b);
        mem[key(s, a)]   = b;
        ref_m[key(s, a)] = b;
    endtask

    // PMOD model: capture nibbles on rising qspi_clk, serve reads on falling edges
    logic [3:0] cap_d [$];
    logic       cap_oe [$];
    int         cap_sel = 0;
    logic [2:0] sel_n;
    logic       all_hi;
    int         low_cnt [3];

    assign sel_n  = {qspi_ram_b_select, qspi_ram_a_select, qspi_flash_select};
    assign all_hi = &sel_n;

    initial for (int i = 0; i < 3; i++) low_cnt[i] = 0;

    always @(negedge clk)
        for (int i = 0; i < 3; i++)
            if (sel_n[i] == 1'b0) low_cnt[i] <= low_cnt[i] + 1;

    function automatic logic [23:0] cap_addr(input int base);
        logic [23:0] a = 24'h0;
        for (int i = 0; i < 6; i++) a = {a[19:0], cap_d[base + i]};
        return a;
    endfunction

    always @(posedge qspi_clk) begin
        if (sel_n != 3'b111) begin
            if (cap_d.size() == 0)
                cap_sel = !sel_n[0] ? 0 : (!sel_n[1] ? 1 : 2);
            cap_d.push_back(qspi_data_out);
            cap_oe.push_back(qspi_data_oe);
        end
    end

    always @(negedge qspi_clk) begin : drv
        int e, base, j;
        logic [7:0] b;
        e    = cap_d.size() + 1;
        base = (cap_sel == 0) ? 0 : 2;
        j    = e - 12 - RD;
        qspi_data_in = 4'h0;
        if (sel_n != 3'b111 && cap_d.size() >= base + 6 && j >= 0) begin
            if (cap_sel == 0 || cap_d[1] == 4'hB) begin
                b = mget(cap_sel, cap_addr(base) + 24'(j / 2));
                qspi_data_in = (j % 2 == 0) ? b[7:4] : b[3:0];
            end
        end
    end

    always @(posedge all_hi) begin : commit
        int nb;
        logic [23:0] a;
        if (cap_sel != 0 && cap_d.size() >= 8 && cap_d[1] == 4'h2) begin
            a  = cap_addr(2);
            nb = (cap_d.size() - 8) / 2;
            for (int i = 0; i < nb; i++)
                mem[key(cap_sel, a + 24'(i))] = {cap_d[8 + 2 * i], cap_d[9 + 2 * i]};
        end
    end

    task automatic clear_cap();
        cap_d.delete();
        cap_oe.delete();
    endtask

    task automatic check_bus(input string nm, input logic [1:0] sel, input logic wr,
                             input logic [23:0] addr, input logic [1:0] len,
                             input logic [31:0] wd);
        logic [4:0] eq [$];
        int nb = int'(len) + 1;
        int bad = -1;
        if (sel != 2'd0) begin
            eq.push_back({1'b1, 4'h0});
            eq.push_back({1'b1, wr ? 4'h2 : 4'hB});
        end
        for (int i = 5; i >= 0; i--) eq.push_back({1'b1, addr[4 * i +: 4]});
        if (sel == 2'd0) begin
            eq.push_back({1'b1, 4'hA});
            eq.push_back({1'b1, 4'h0});
        end
        if (wr) begin
            for (int i = 0; i < nb; i++) begin
                eq.push_back({1'b1, wd[8 * i + 4 +: 4]});
                eq.push_back({1'b1, wd[8 * i +: 4]});
            end
        end else begin
            for (int i = 0; i < 3 + RD + 2 * nb; i++) eq.push_back(5'h00);
        end
        chk({nm, "_edges"}, cap_d.size(), eq.size());
        for (int i = 0; i < eq.size() && i < cap_d.size(); i++)
            if (bad < 0 && (cap_oe[i] !== eq[i][4] || (eq[i][4] && cap_d[i] !== eq[i][3:0])))
                bad = i;
        chk({nm, "_bus_bad_idx"}, bad, -1);
    endtask

    task automatic wait_ready(input string nm);
        int g = 0;
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk({nm, "_ready"}, req_ready, 1'b1);
    endtask

    task automatic run_txn(input string nm, input logic [1:0] sel, input logic wr,
                           input logic [23:0] addr, input logic [1:0] len,
                           input logic [31:0] wd, input logic [31:0] exp_rd,
                           input logic exp_err, input int exp_cyc);
        int cyc = 0;
        bit got = 0;
        int l0 [3];
        logic [2:0] seen = 3'b000;
        logic ill = (sel == 2'd3) || (sel == 2'd0 && wr);
        @(negedge clk);
        clear_cap();
        for (int i = 0; i < 3; i++) l0[i] = low_cnt[i];
        req_valid = 1'b1; req_sel = sel; req_write = wr;
        req_addr = addr; req_len = len; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        while (!got && cyc < 300) begin
            @(negedge clk);
            cyc++;
            got = resp_valid;
        end
        chk({nm, "_cycle"}, got ? cyc : -1, exp_cyc);
        chk({nm, "_rdata"}, resp_rdata, exp_rd);
        chk({nm, "_error"}, resp_error, exp_err);
        for (int i = 0; i < 3; i++) seen[i] = (low_cnt[i] != l0[i]);
        chk({nm, "_selects"}, seen, ill ? 3'b000 : (3'b001 << sel));
        if (!ill) check_bus(nm, sel, wr, addr, len, wd);
        wait_ready(nm);
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic        wr;
        logic [23:0] addr;
        logic [1:0]  len;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } vec_t;

    vec_t tab [10];

    function automatic int exp_cycles(input logic wr, input logic [1:0] len);
        int nb = int'(len) + 1;
        int n  = wr ? 8 + 2 * nb : 12 + RD + 2 * nb - 1;
        return 2 * n + 2;
    endfunction

    int          rs, ncnt, second, gap, nresp, g;
    logic        rw, ill;
    logic [1:0]  rl;
    logic [23:0] ra;
    logic [31:0] rwd, rexp;

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_sel = 2'd0; req_write = 1'b0;
        req_addr = 24'h0; req_len = 2'd0; req_wdata = 32'h0; qspi_data_in = 4'h0;
`ifdef QSPI_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        for (int s = 0; s < 3; s++)
            for (int a = 0; a < 64; a++)
                preload(s, 24'(a), 8'($urandom));
        preload(0, 24'h10, 8'h11); preload(0, 24'h11, 8'h22);
        preload(0, 24'h12, 8'h33); preload(0, 24'h13, 8'h44);
        preload(2, 24'h200, 8'h5A); preload(2, 24'h302, 8'h77);

        tab[0] = '{2'd0, 1'b0, 24'h000010, 2'd3, 32'h0, 32'h44332211, 1'b0, 44};
        tab[1] = '{2'd1, 1'b1, 24'h000100, 2'd3, 32'hDEADBEEF, 32'h0, 1'b0, 34};
        tab[2] = '{2'd1, 1'b0, 24'h000100, 2'd3, 32'h0, 32'hDEADBEEF, 1'b0, 44};
        tab[3] = '{2'd2, 1'b0, 24'h000200, 2'd0, 32'h0, 32'h0000005A, 1'b0, 32};
        tab[4] = '{2'd3, 1'b0, 24'h000010, 2'd3, 32'h0, 32'h0, 1'b1, 1};
        tab[5] = '{2'd0, 1'b1, 24'h000010, 2'd3, 32'h12345678, 32'h0, 1'b1, 1};
        tab[6] = '{2'd2, 1'b1, 24'h000300, 2'd1, 32'h0000C3A5, 32'h0, 1'b0, 26};
        tab[7] = '{2'd2, 1'b0, 24'h000300, 2'd2, 32'h0, 32'h0077C3A5, 1'b0, 40};
        tab[8] = '{2'd0, 1'b0, 24'h000011, 2'd1, 32'h0, 32'h00003322, 1'b0, 36};
        tab[9] = '{2'd1, 1'b0, 24'h000102, 2'd0, 32'h0, 32'h000000AD, 1'b0, 32};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_state",
            {qspi_clk, qspi_data_out, qspi_data_oe, sel_n, req_ready,
             resp_valid, resp_error, resp_rdata},
            {1'b0, 4'h0, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 32'h0});

        for (int i = 0; i < 10; i++)
            run_txn($sformatf("vec%0d", i), tab[i].sel, tab[i].wr, tab[i].addr,
                    tab[i].len, tab[i].wd, tab[i].rd, tab[i].err, tab[i].cyc);

        for (int i = 0; i < 40; i++) begin
            rs  = int'($urandom_range(0, 3));
            rw  = 1'($urandom_range(0, 1));
            ra  = 24'($urandom_range(0, 60));
            rl  = 2'($urandom_range(0, 3));
            rwd = $urandom;
            ill = (rs == 3) || (rs == 0 && rw);
            rexp = 32'h0;
            if (!ill && !rw)
                for (int b = 0; b <= int'(rl); b++)
                    rexp[8 * b +: 8] = rget(rs, ra + 24'(b));
            if (!ill && rw)
                for (int b = 0; b <= int'(rl); b++)
                    ref_m[key(rs, ra + 24'(b))] = rwd[8 * b +: 8];
            run_txn($sformatf("rnd%0d", i), 2'(rs), rw, ra, rl, rwd, rexp,
                    ill, ill ? 1 : exp_cycles(rw, rl));
        end

        // back-to-back with req_valid held high
        @(negedge clk);
        clear_cap();
        req_valid = 1'b1; req_sel = 2'd1; req_write = 1'b0;
        req_addr = 24'h20; req_len = 2'd0;
        second = -1; gap = 0;
        for (int k = 1; k < 100 && second < 0; k++) begin
            @(negedge clk);
            if (req_ready) begin
                second = k;
                clear_cap();
            end else if (k > 2 && qspi_ram_a_select) begin
                gap++;
            end
        end
        chk("b2b_second_accept", second, 34);
        chk("b2b_gap_ge2", gap >= 2, 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        ncnt = 0;
        while (!resp_valid && ncnt < 300) begin
            @(negedge clk);
            ncnt++;
        end
        chk("b2b_second_cycle", ncnt, 32);
        chk("b2b_second_rdata", resp_rdata, {24'h0, rget(1, 24'h20)});
        wait_ready("b2b");

        // reset in the middle of the address phase
        @(negedge clk);
        clear_cap();
        req_valid = 1'b1; req_sel = 2'd1; req_write = 1'b0;
        req_addr = 24'h30; req_len = 2'd1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("rst_pre_sel_low", qspi_ram_a_select, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_selects_high", sel_n, 3'b111);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        nresp = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (resp_valid) nresp++;
        end
        chk("rst_no_resp", nresp, 0);
        chk("rst_ready", req_ready, 1'b1);

`ifdef QSPI_CTRL_ABORT_EN
        @(negedge clk);
        clear_cap();
        req_valid = 1'b1; req_sel = 2'd1; req_write = 1'b0;
        req_addr = 24'h100; req_len = 2'd3;
        @(posedge clk);
        #1 req_valid = 1'b0;
        g = 0;
        while (cap_d.size() < 12 + RD + 1 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("abort_reached_byte0", cap_d.size(), 12 + RD + 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_sel_high", qspi_ram_a_select, 1'b1);
        chk("abort_resp_valid", resp_valid, 1'b1);
        chk("abort_resp_error", resp_error, 1'b1);
        chk("abort_rdata", resp_rdata, {24'h0, mget(1, 24'h100)});
        chk("abort_rdata_ref", resp_rdata, 32'h000000EF);
        wait_ready("abort");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
